// File: rtl/psr_pkg.sv
// psr_pkg: flag layout, ALU opcodes and condition codes shared by the PSR, ALU and decoder.
package psr_pkg;
    localparam int PSR_W = 5;
    localparam int PSR_C = 0;
    localparam int PSR_F = 1;
    localparam int PSR_L = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_CMP = 4'b0101;
    localparam logic [PSR_W-1:0] MASK_ARITH = 5'b00011;
    localparam logic [PSR_W-1:0] MASK_CMP = 5'b11100;
    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_HI, COND_LS, COND_GT, COND_LE,
        COND_FS, COND_FC, COND_LO, COND_HS, COND_LT, COND_GE, COND_UC, COND_NV
    } cond_e;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational branch/jump condition check against a flag vector.
module cond_eval
    import psr_pkg::*;
(
    input  logic [3:0]       cond,
    input  logic [PSR_W-1:0] flags,
    output logic             met
);
    logic c, f, l, z, n;
    assign c = flags[PSR_C];
    assign f = flags[PSR_F];
    assign l = flags[PSR_L];
    assign z = flags[PSR_Z];
    assign n = flags[PSR_N];
    always_comb begin
        met = 1'b0;
        case (cond)
            COND_EQ: met = z;
            COND_NE: met = !z;
            COND_CS: met = c;
            COND_CC: met = !c;
            COND_HI: met = l;
            COND_LS: met = !l;
            COND_GT: met = n;
            COND_LE: met = !n;
            COND_FS: met = f;
            COND_FC: met = !f;
            COND_LO: met = !l && !z;
            COND_HS: met = l || z;
            COND_LT: met = !n && !z;
            COND_GE: met = n || z;
            COND_UC: met = 1'b1;
            COND_NV: met = 1'b0;
        endcase
    end
endmodule

// File: rtl/psr_unit.sv
// psr_unit: masked ALU flag capture, LPR load, interrupt shadow and forwarded condition evaluation.
module psr_unit
    import psr_pkg::*;
#(
    parameter int WIDTH = PSR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    input  logic [3:0]       alucont,
    input  logic [WIDTH-1:0] alu_psr,
    input  logic             psr_wr_en,
    input  logic [WIDTH-1:0] psr_wr_data,
    input  logic             irq_save,
    input  logic             irq_restore,
    input  logic             cond_valid,
    input  logic [3:0]       cond,
    output logic             taken_valid,
    output logic             taken,
    output logic [WIDTH-1:0] psr,
    output logic [WIDTH-1:0] shadow
);
    logic [WIDTH-1:0] mask, alu_next, psr_next;
    logic             met;
    assign mask = !alu_valid ? '0 :
                  (alucont == ALU_ADD || alucont == ALU_SUB) ? MASK_ARITH :
                  (alucont == ALU_CMP) ? MASK_CMP : '0;
    assign alu_next = (psr & ~mask) | (alu_psr & mask);
    assign psr_next = irq_restore ? shadow : psr_wr_en ? psr_wr_data : alu_next;
    // Evaluate against next-PSR so a branch sees flags retiring in the same cycle.
    cond_eval u_cond_eval (
        .cond  (cond),
        .flags (psr_next),
        .met   (met)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psr         <= '0;
            shadow      <= '0;
            taken       <= 1'b0;
            taken_valid <= 1'b0;
        end else begin
            psr         <= psr_next;
            taken_valid <= cond_valid;
            if (irq_save) shadow <= psr;
            if (cond_valid) taken <= met;
        end
    end
endmodule

// File: doc/psr_unit.md
# psr_unit

Processor status register stage directly downstream of the ALU. Captures the ALU's 5-bit flag vector (C F L Z N) under per-opcode update masks, holds it across instructions, and evaluates 4-bit branch/jump condition codes against it with same-cycle forwarding. Also provides a one-deep shadow copy for interrupt entry and exit, and a software load path (LPR). Its outputs feed the fetch/PC-select logic and the register-file read mux.

## Interface
- `WIDTH`, 5: flag vector width. Fixed at 5; bit order is C=0, F=1, L=2, Z=3, N=4.
- `clk  in  1`: single clock; all state is rising-edge.
- `reset  in  1`: asynchronous, active-low; clears all state.
- `alu_valid  in  1`: ALU op retiring this cycle.
- `alucont  in  4`: ALU opcode of the retiring op.
- `alu_psr  in  5`: ALU flag output.
- `psr_wr_en  in  1`: software PSR load (LPR).
- `psr_wr_data  in  5`: value for the LPR load.
- `irq_save  in  1`: one-cycle pulse; copy the PSR to the shadow.
- `irq_restore  in  1`: one-cycle pulse; copy the shadow to the PSR.
- `cond_valid  in  1`: condition-evaluation request.
- `cond  in  4`: condition code.
- `taken_valid  out  1`: registered; `cond_valid` delayed by one cycle.
- `taken  out  1`: registered evaluation result; qualified by `taken_valid`.
- `psr  out  5`: current PSR register.
- `shadow  out  5`: current shadow register.

## Operation
- Update masks by `alucont`, applied only when `alu_valid=1`:
  - 0000 (ADD) and 0001 (SUB): write C and F; L, Z and N hold.
  - 0101 (CMP): write L, Z and N; C and F hold.
  - All other opcodes: no flag change.
- Next-PSR priority:
  1. reset
  2. `irq_restore` (PSR takes the shadow)
  3. `psr_wr_en` (PSR takes `psr_wr_data`)
  4. masked ALU update
  5. hold
- Shadow: on `irq_save` it takes the current registered PSR, i.e. the pre-update value of that cycle. Save and restore asserted in the same cycle swap the two registers.
- Forwarding: condition evaluation uses next-PSR, the value the PSR register will hold after the edge. A CMP followed in the same cycle by a branch therefore sees the CMP's flags.
- Condition codes, evaluated against next-PSR:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 HI: L
  - 0101 LS: !L
  - 0110 GT: N
  - 0111 LE: !N
  - 1000 FS: F
  - 1001 FC: !F
  - 1010 LO: !L & !Z
  - 1011 HS: L | Z
  - 1100 LT: !N & !Z
  - 1101 GE: N | Z
  - 1110 UC: 1
  - 1111: never, 0
- When `cond_valid=0`, `taken` holds its previous value. `taken_valid` is the only qualifier.

## Timing
- Reset values: `psr`=0, `shadow`=0, `taken`=0, `taken_valid`=0. Reset asserted mid-operation clears everything immediately, including a pending `taken_valid`.
- PSR update latency: 1 cycle. Flags presented at edge N are visible on `psr` after edge N.
- Condition latency: 1 cycle. A request at edge N produces `taken_valid=1` and `taken` after edge N, and `taken_valid` stays high for exactly one cycle per request.
- Back-to-back requests are supported every cycle; there is no stall or backpressure.
- `irq_save` and `irq_restore` are single-cycle pulses. A level held high repeats the action every cycle, which is harmless and idempotent for save.
- An `alu_valid` op whose mask is empty (AND, XOR, OR, MOV, shifts, LUI, RANI) has no effect. The PSR must not glitch-update.

## Structure
- Shared package `psr_pkg`:
  - flag index constants `PSR_C`..`PSR_N`
  - `alucont` opcode constants (ADD=4'b0000, SUB=4'b0001, CMP=4'b0101, ...), shared with the ALU and decoder
  - condition-code constants `COND_EQ`..`COND_NV`
- Sub-module `cond_eval`: purely combinational, with inputs `cond[3:0]` and `flags[4:0]` and output `met`. It is reused by the PC-select logic.
- Top level: mask decode, next-PSR priority mux, PSR, shadow and output registers.

## Test plan
- Reset, then ADD with `alu_psr`=5'b11111 → `psr`=5'b00011. Next, CMP with 5'b11100 → `psr`=5'b11111. Next, SUB with 5'b00000 → `psr`=5'b11100.
- Same-cycle forwarding: `psr`=0, then CMP with `alu_psr`=5'b01000 together with `cond_valid`, `cond`=EQ → next cycle `taken_valid`=1, `taken`=1, `psr`=5'b01000.
- Sweep all 16 codes against `psr`=5'b00000, then against 5'b11111 → for 00000 expect NE, CC, LS, LE, FC, LO, LT and UC true, all others false. For 11111 expect EQ, CS, HI, GT, FS, HS, GE and UC true. Code 1111 is never true.
- Save/restore: `psr`=5'b10101, `irq_save` → `shadow`=5'b10101. LPR 5'b01010, then `irq_restore` → `psr`=5'b10101. Same-cycle save and restore → the two registers swap.
- Priority: `irq_restore`, `psr_wr_en` and an ADD in one cycle → PSR takes the shadow value.
- Reset asserted asynchronously mid-cycle, while `taken_valid`=1 and `psr`≠0 → all outputs 0 immediately, without waiting for a clock edge.
